// File: rtl/writeback_unit.sv
// writeback_unit: merges single-cycle ALU results and variable-latency load
// results onto the single register-file write port. Load results that lose
// arbitration wait in a small circular FIFO. A per-register scoreboard tracks
// outstanding loads for decode's load-use stall.
// Optional feature macro: WRITEBACK_BYPASS_EN. When it is defined, a load that
// arrives with the FIFO empty and no ALU result skips the FIFO.
module writeback_unit #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [2:0]  alu_rd,
  input  logic [15:0] alu_data,
  input  logic        mem_valid,
  input  logic [2:0]  mem_rd,
  input  logic [15:0] mem_data,
  output logic        mem_ready,
  input  logic        load_issue,
  input  logic [2:0]  load_rd,
  output logic [7:0]  pending,
  output logic        reg_write,
  output logic [2:0]  write_reg,
  output logic [15:0] write_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Load-result storage: destination and data kept side by side.
  logic [2:0]    fifo_rd   [FIFO_DEPTH];
  logic [15:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        bypass;
  logic        fifo_write;
  logic [2:0]  head_rd;
  logic [15:0] head_data;

  logic        reg_write_next;
  logic [2:0]  write_reg_next;
  logic [15:0] write_data_next;
  logic [7:0]  clr_mask;
  logic [7:0]  set_mask;
  logic [7:0]  pending_next;

  assign fifo_empty = (count == '0);
  assign mem_ready  = (count != CW'(FIFO_DEPTH));
  assign push       = mem_valid && mem_ready;
  assign pop        = !alu_valid && !fifo_empty;
  assign head_rd    = fifo_rd[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

`ifdef WRITEBACK_BYPASS_EN
  assign bypass = push && fifo_empty && !alu_valid;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_write = push && !bypass;

  // Write-port arbitration (ALU > FIFO head > bypassed load) and scoreboard update.
  always_comb begin
    reg_write_next  = 1'b0;
    write_reg_next  = write_reg;
    write_data_next = write_data;
    clr_mask        = 8'h00;
    set_mask        = 8'h00;
    if (alu_valid) begin
      reg_write_next  = (alu_rd != 3'd0);
      write_reg_next  = alu_rd;
      write_data_next = alu_data;
    end else if (!fifo_empty) begin
      reg_write_next  = (head_rd != 3'd0);
      write_reg_next  = head_rd;
      write_data_next = head_data;
      clr_mask        = 8'h01 << head_rd;
    end else if (bypass) begin
      reg_write_next  = (mem_rd != 3'd0);
      write_reg_next  = mem_rd;
      write_data_next = mem_data;
      clr_mask        = 8'h01 << mem_rd;
    end
    if (load_issue && (load_rd != 3'd0)) begin
      set_mask = 8'h01 << load_rd;
    end
    // Set wins over a same-cycle clear; register 0 never goes pending.
    pending_next    = (pending & ~clr_mask) | set_mask;
    pending_next[0] = 1'b0;
  end

  // FIFO storage has no reset: an empty count makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (fifo_write) begin
      fifo_rd[wr_ptr]   <= mem_rd;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  // FIFO pointers and occupancy; occupancy moves by at most one per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(fifo_write) - CW'(pop);
    end
  end

  // Registered write-port outputs and scoreboard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write  <= 1'b0;
      write_reg  <= 3'd0;
      write_data <= 16'h0000;
      pending    <= 8'h00;
    end else begin
      reg_write  <= reg_write_next;
      write_reg  <= write_reg_next;
      write_data <= write_data_next;
      pending    <= pending_next;
    end
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-side initiator for the 8×16-bit register file. It merges single-cycle ALU results and variable-latency memory load results into the file's single write port, driving `reg_write`, `write_reg` and `write_data` from registers. It buffers load results that lose arbitration in a small FIFO. It also keeps a per-register pending-load scoreboard that decode uses to stall on load-use hazards.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: load-result buffer entries; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `alu_valid`  in  1  ALU result present this cycle; always accepted.
- `alu_rd`  in  3  ALU destination register.
- `alu_data`  in  16  ALU result.
- `mem_valid`  in  1  load result offered.
- `mem_rd`  in  3  load destination register.
- `mem_data`  in  16  load data.
- `mem_ready`  out  1  unit accepts a load result; a push occurs when `mem_valid && mem_ready`.
- `load_issue`  in  1  a load to `load_rd` was issued this cycle.
- `load_rd`  in  3  destination of the issued load.
- `pending`  out  8  scoreboard; bit r high means a load to register r is outstanding.
- `reg_write`  out  1  register-file write enable (registered).
- `write_reg`  out  3  register-file write address (registered).
- `write_data`  out  16  register-file write data (registered).

## Operation
- Arbitration is evaluated each cycle, highest priority first:
  1. `alu_valid`: the ALU result goes to the output registers.
  2. FIFO non-empty: pop the head entry to the output registers.
  3. Otherwise no write.
- A load result that is pushed always enters the FIFO, except under bypass (see Configuration).
- The ALU is never back-pressured. Sustained ALU traffic can starve the FIFO; `mem_ready` then drops once the FIFO is full.
- `mem_ready` = (FIFO count != `FIFO_DEPTH`), decoded from registered state.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - While `mem_ready` is low, the source holds `mem_valid`, `mem_rd` and `mem_data` stable.
- Destination register 0:
  - the entry is consumed (the FIFO pops) but `reg_write` stays 0;
  - `write_reg` and `write_data` still update.
- Scoreboard behaviour:
  - `load_issue` sets `pending[load_rd]`.
  - Writing a load result to the output clears `pending[rd]`.
  - If set and clear hit the same register in the same cycle, set wins.
  - `load_issue` to register 0 is ignored; `pending[0]` is always 0.
  - ALU writes never touch the scoreboard.
- Decode contract, enforced by decode and not checked here: no instruction reads or writes a register whose `pending` bit is set. This rules out WAW between the ALU and loads and double-outstanding loads to the same register.
- FIFO: circular buffer with log2(`FIFO_DEPTH`)-bit pointers, wrap-around, and a count of width log2(`FIFO_DEPTH`)+1.

## Timing
- Reset values:
  - outputs: `reg_write`=0, `write_reg`=0, `write_data`=0, `pending`=0;
  - FIFO: empty, so `mem_ready`=1.
  - Inputs are ignored while `reset` is high.
- Reset mid-operation discards buffered load results and clears all pending bits.
- ALU latency: `alu_valid` sampled at edge N gives `reg_write`=1 during cycle N+1, one cycle only.
- Load latency without bypass:
  - push at N;
  - entry visible at N+1, popped if `alu_valid` is low at N+1;
  - `reg_write` during N+2.
  - Each ALU-valid cycle in the meantime adds one cycle.
- Scoreboard: `pending` is registered. A `load_issue` at N shows at N+1. The bit drops in the same cycle that `reg_write` presents the matching result.
- Throughput: one register-file write per cycle. FIFO occupancy changes by at most +1 or −1 per cycle.

## Configuration
- `WRITEBACK_BYPASS_EN`
  - Defined: a load result pushed while the FIFO is empty and `alu_valid` is low goes straight to the output registers, with `reg_write` during N+1. The FIFO is not written.
  - Undefined: every accepted load passes through the FIFO, giving a minimum load latency of 2 cycles.
  - Ports, priority and scoreboard behaviour are identical in both builds.

## Test plan
- ALU only: `alu_valid`=1, `alu_rd`=3, `alu_data`=16'h1234 at N → during N+1 `reg_write`=1, `write_reg`=3, `write_data`=16'h1234; during N+2 `reg_write`=0.
- Load via FIFO: `load_issue` with rd=5, then a push of rd=5, data 16'hBEEF → `pending[5]`=1 until `reg_write` presents reg 5 / 16'hBEEF (N+2, or N+1 with bypass), then 0.
- Conflict: ALU (rd=1, data=1) and load (rd=2, data=2) in the same cycle → reg 1 written at N+1, reg 2 written at N+2, `mem_ready` stays 1.
- Back-pressure: `alu_valid` held high while 5 loads are offered (`FIFO_DEPTH`=4) → `mem_ready`=0 after 4 pushes. Release the ALU → 4 loads are written in push order, wrapping the pointers, and `mem_ready` returns to 1.
- Register 0: ALU and load results with rd=0, plus `load_issue` to 0 → `reg_write` never asserts, FIFO drains, `pending`=8'h00.
- Reset mid-operation: FIFO holds 3 entries and `pending`=8'h0E, then assert `reset` → all outputs 0, `mem_ready`=1, no writes after release.
